// File: rtl/dmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg : shared constants and read-pipeline entry type          |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DEPTH  = 256;

  // Pipeline entries carry DMEM_DATA_W data bits; narrower words are zero-extended.
  typedef struct packed {
    logic                   valid;
    logic [DMEM_DATA_W-1:0] data;
    logic                   err;
  } rd_entry_t;

endpackage
`default_nettype wire

// File: rtl/dmem_rsp_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_rsp_fifo : circular response FIFO with push/pop and count    |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
module dmem_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CNTW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= f_next(r_wptr);
      if (w_pop)  r_rptr <= f_next(r_rptr);
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_ctrl : byte-enabled data memory, pipelined reads, credit flow|
// | Option    : DMEM_BOUNDS_CHECK_EN flags addresses >= DEPTH         |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int READ_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB     = DATA_W / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int FIFO_D = READ_LAT + 1;
  localparam int CW     = $clog2(READ_LAT + 2);

  logic [DATA_W-1:0]             r_mem [DEPTH];
  rd_entry_t                     r_pipe [READ_LAT];
  logic [CW-1:0]                 r_credit;
  logic                          r_ready;

  logic [AW-1:0]                 w_idx;
  logic                          w_oob;
  logic                          w_acc;
  logic                          w_rd_acc;
  logic                          w_wr_acc;
  logic                          w_pop;
  logic [CW-1:0]                 w_credit_nxt;
  logic [DATA_W:0]               w_head;
  logic                          w_full;
  logic                          w_empty;
  logic [$clog2(FIFO_D+1)-1:0]   w_count;
  logic                          w_unused;

  assign w_idx = req_addr[AW-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_oob = (64'(req_addr) >= 64'(DEPTH));
`else
  assign w_oob = 1'b0;
`endif

  assign req_ready = r_ready & ~reset;
  assign w_acc     = req_valid & req_ready;
  assign w_rd_acc  = w_acc & ~req_we;
  assign w_wr_acc  = w_acc & req_we & ~w_oob;

  assign rsp_valid = ~w_empty;
  assign w_pop     = rsp_valid & rsp_ready;
  assign rsp_rdata = rsp_valid ? w_head[DATA_W-1:0] : '0;
  assign rsp_err   = rsp_valid & w_head[DATA_W];

  assign w_unused  = &{1'b0, w_full, w_count, req_addr};

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) r_mem[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  // Stage 1 captures the array word; later stages only shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0].valid <= w_rd_acc;
      r_pipe[0].err   <= w_oob;
      r_pipe[0].data  <= w_oob ? '0 : DMEM_DATA_W'(r_mem[w_idx]);
      for (int i = 1; i < READ_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Credits cover every in-flight read plus every queued response, so the FIFO never overflows.
  assign w_credit_nxt = r_credit - CW'(w_rd_acc) + CW'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit <= CW'(FIFO_D);
      r_ready  <= 1'b1;
    end else begin
      r_credit <= w_credit_nxt;
      r_ready  <= (w_credit_nxt != '0);
    end
  end

  dmem_rsp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_D)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_pipe[READ_LAT-1].valid),
    .i_data  ({r_pipe[READ_LAT-1].err, DATA_W'(r_pipe[READ_LAT-1].data)}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_ctrl : directed self-checking bench for dmem_ctrl         |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
module tb_dmem_ctrl;

  localparam int DW  = 32;
  localparam int AWD = 32;
  localparam int DEP = 256;
  localparam int RL  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [DW/8-1:0] req_be;
  logic [AWD-1:0]  req_addr;
  logic [DW-1:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int checks = 0;
  int errors = 0;
  int acc;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AWD),
    .DEPTH    (DEP),
    .READ_LAT (RL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    chk1("wr_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Response must appear exactly RL edges after the acceptance edge.
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err,
                    input string tag);
    chk1({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < RL; k++) begin
      chk1({tag, "_early"}, rsp_valid, 1'b0);
      tick();
    end
    chk1({tag, "_valid"}, rsp_valid, 1'b1);
    chk32({tag, "_data"}, rsp_rdata, exp);
    chk1({tag, "_err"}, rsp_err, exp_err);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    reset = 1'b0;
    #1;
    chk1("post_rst_ready", req_ready, 1'b1);

    // Full-word write then read back
    wr(32'd10, 32'hDEADBEEF, 4'hF);
    rd(32'd10, 32'hDEADBEEF, 1'b0, "rd_a10");
    tick();
    chk1("a10_popped", rsp_valid, 1'b0);
    chk32("idle_rdata_zero", rsp_rdata, 32'h0);

    // Byte-lane merge, read issued the cycle right after the write
    wr(32'd3, 32'h11223344, 4'hF);
    wr(32'd3, 32'hAABBCCDD, 4'h2);
    rd(32'd3, 32'h1122CC44, 1'b0, "rd_a3_be");
    tick();

    // Back-pressure: credits limit outstanding reads to RL+1
    wr(32'd20, 32'hA0000000, 4'hF);
    wr(32'd21, 32'hA0000001, 4'hF);
    wr(32'd22, 32'hA0000002, 4'hF);
    rsp_ready = 1'b0;
    acc       = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_addr = 32'(20 + acc);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk32("stall_accepts", 32'(acc), 32'(RL + 1));
    chk1("stall_ready_low", req_ready, 1'b0);
    chk1("stall_valid", rsp_valid, 1'b1);
    chk32("stall_head", rsp_rdata, 32'hA0000000);
    tick();
    chk32("stall_hold", rsp_rdata, 32'hA0000000);
    chk1("stall_hold_err", rsp_err, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i <= RL; i++) begin
      chk1("drain_valid", rsp_valid, 1'b1);
      chk32("drain_data", rsp_rdata, 32'hA0000000 + 32'(i));
      tick();
    end
    chk1("drain_empty", rsp_valid, 1'b0);
    chk32("drain_rdata_zero", rsp_rdata, 32'h0);
    chk1("drain_ready", req_ready, 1'b1);

    // Reset with two reads in flight
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'd10;
    tick();
    req_addr  = 32'd3;
    tick();
    req_valid = 1'b0;
    reset     = 1'b1;
    tick();
    chk1("mid_rst_ready", req_ready, 1'b0);
    chk1("mid_rst_valid", rsp_valid, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk1("mid_rst_ready_after", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("no_stale_rsp", rsp_valid, 1'b0);
      tick();
    end
    rd(32'd10, 32'hDEADBEEF, 1'b0, "rst_keep_a10");
    tick();

    // Address beyond DEPTH
    wr(32'd44, 32'h44444444, 4'hF);
    wr(32'd300, 32'h30030030, 4'hF);
`ifdef DMEM_BOUNDS_CHECK_EN
    rd(32'd300, 32'h0, 1'b1, "oob_rd300");
    tick();
    rd(32'd44, 32'h44444444, 1'b0, "oob_a44");
`else
    rd(32'd300, 32'h30030030, 1'b0, "wrap_rd300");
    tick();
    rd(32'd44, 32'h30030030, 1'b0, "wrap_a44");
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32, word-address width of req_addr.
REQ-003 Parameter DEPTH, default 256, number of words; SHALL be a power of two.
REQ-004 Parameter READ_LAT, default 2, range 1..4, clocks from read acceptance to response.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request can be accepted this cycle.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_be  in  DATA_W/8  byte write enables; ignored on reads.
REQ-011 req_addr  in  ADDR_W  word address.
REQ-012 req_wdata  in  DATA_W  write data.
REQ-013 rsp_valid  out  1  read response present.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_rdata  out  DATA_W  read data.
REQ-016 rsp_err  out  1  response address error flag.

Function
REQ-017 Request accepted on an edge where req_valid && req_ready; at most one per cycle.
REQ-018 Accepted write SHALL update only bytes with req_be[i]=1, at the acceptance edge; writes produce no response.
REQ-019 Accepted read SHALL enter a READ_LAT-stage pipeline; stage 1 is the registered array read.
REQ-020 Read results SHALL be pushed into a response FIFO of depth READ_LAT+1 at pipeline exit; FIFO head drives rsp_*.
REQ-021 With FIFO empty and rsp_ready=1, rsp_valid SHALL assert exactly READ_LAT cycles after the acceptance edge.
REQ-022 Response popped on an edge where rsp_valid && rsp_ready; responses SHALL return in request order.
REQ-023 Credit counter = FIFO depth minus (reads in pipeline + FIFO occupancy); req_ready SHALL be 1 iff credit > 0, deasserting combinationally-free (registered) with no request lost.
REQ-024 Writes SHALL be accepted whenever req_ready=1 and consume no credit.
REQ-025 Read following a write to the same address in the next cycle SHALL return the new data.
REQ-026 Simultaneous push and pop SHALL keep FIFO occupancy unchanged; credit SHALL count both.
REQ-027 rsp_rdata and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-028 When rsp_valid=0, rsp_rdata SHALL be 0.

Reset
REQ-029 While reset=1: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; pipeline valids and FIFO cleared; credit set to READ_LAT+1.
REQ-030 Reset mid-operation SHALL discard in-flight reads and queued responses; memory contents SHALL NOT be cleared.
REQ-031 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-032 Macro DMEM_BOUNDS_CHECK_EN defined: req_addr >= DEPTH suppresses writes, reads return rsp_rdata=0 with rsp_err=1.
REQ-033 Macro undefined: array index = req_addr[$clog2(DEPTH)-1:0] (wrap-around), rsp_err tied 0.

Structure
REQ-034 Package dmem_pkg SHALL hold default DATA_W/ADDR_W/DEPTH constants and the read-pipeline entry typedef (valid, data, err).
REQ-035 The response FIFO SHALL be sub-module dmem_rsp_fifo (parametrised width/depth, push/pop, full/empty, count).

Verification
REQ-036 Write 0xDEADBEEF to addr 10 be=0xF, read addr 10, rsp_ready=1 -> rsp_rdata=0xDEADBEEF, READ_LAT cycles after acceptance.
REQ-037 Write 0x11223344 to addr 3, then write 0xAABBCCDD be=0x2 -> read addr 3 returns 0x1122CC44.
REQ-038 rsp_ready=0, issue reads back-to-back -> exactly READ_LAT+1 accepted, req_ready=0 after; raise rsp_ready -> all returned in order, no loss.
REQ-039 Reset asserted with 2 reads in flight -> rsp_valid=0 after reset, no stale responses; memory data at addr 10 preserved.
REQ-040 DMEM_BOUNDS_CHECK_EN defined, DEPTH=256: write addr 300 then read addr 300 -> rsp_err=1, rsp_rdata=0, addr 44 unchanged; macro undefined -> read addr 300 returns addr 44 contents.
